// File: rtl/rv32_prefetch_buffer.sv
// ---------------------------------------------------------------------------------------------
// rv32_prefetch_buffer
//
// Instruction prefetch stage between instruction memory and decode. Issues sequential word
// fetches ahead of decode (at most MAX_OUT granted-but-unanswered requests) and buffers the
// returned words together with their PC in a DEPTH-entry FIFO. A redirect flushes the FIFO,
// restarts fetching at the new PC and drops every response still in flight.
//
// Optional feature (compile-time macro PFB_BYPASS_EN):
//   When defined, a live response arriving while the FIFO is empty and decode is ready is
//   forwarded straight to instr_o/instr_pc_o in the same cycle instead of being buffered.
//   When undefined, every response goes through the FIFO (one cycle minimum latency).
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous, active-high reset
//   redirect_i     in   flush and restart fetch at redirect_pc_i
//   redirect_pc_i  in   new fetch PC (bits [1:0] ignored)
//   imem_req_o     out  fetch request, held with imem_addr_o until imem_gnt_i
//   imem_addr_o    out  word-aligned fetch address
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   in-order response valid
//   imem_rdata_i   in   response instruction word
//   instr_valid_o  out  {instr_o, instr_pc_o} valid to decode
//   instr_ready_i  in   decode accepts the presented instruction
//   instr_o        out  instruction word
//   instr_pc_o     out  PC of instr_o
// ---------------------------------------------------------------------------------------------
module rv32_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);

  // FIFO storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Fetch bookkeeping.
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;  // granted, no rvalid yet (includes stale ones)
  logic [OutW-1:0] discard_q, discard_d;  // how many of the outstanding are stale

  logic [31:0] redirect_pc_aligned;
  logic [31:0] occupancy;
  logic        grant;
  logic        fifo_empty;
  logic        rsp_keep;
  logic        bypass;
  logic        push;
  logic        pop;

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
  assign fifo_empty          = (fifo_cnt_q == '0);

  // Credit check: buffered words plus live (non-stale) in-flight fetches must leave a free
  // slot, so every live response is guaranteed somewhere to land.
  assign occupancy = 32'(fifo_cnt_q) + 32'(out_cnt_q - discard_q);

  // Request is suppressed while reset is held so the reset state shows no request.
  assign imem_req_o  = !rst_i && !redirect_i && (32'(out_cnt_q) < MAX_OUT) &&
                       (occupancy < DEPTH);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // A response is kept only if it is not stale and no redirect squashes it this cycle.
  assign rsp_keep = imem_rvalid_i && (discard_q == '0) && !redirect_i;

`ifdef PFB_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty && instr_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_keep && !bypass;
  assign pop  = !fifo_empty && instr_ready_i && !redirect_i;

  assign instr_valid_o = !redirect_i && (!fifo_empty || bypass);

  always_comb begin
    instr_o    = fifo_data_q[rd_ptr_q];
    instr_pc_o = fifo_pc_q[rd_ptr_q];
    if (bypass) begin
      instr_o    = imem_rdata_i;
      instr_pc_o = rsp_pc_q;
    end
  end

  // Next-state logic.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    discard_d  = discard_q;
    out_cnt_d  = out_cnt_q + OutW'(grant) - OutW'(imem_rvalid_i);

    if (redirect_i) begin
      // grant is 0 here, so out_cnt_d already reflects only this cycle's rvalid; everything
      // still outstanding afterwards belongs to the old stream.
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
      discard_d  = out_cnt_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - OutW'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      discard_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      discard_q  <= discard_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        fifo_data_q[wr_ptr_q] <= imem_rdata_i;
      end
    end
  end

`ifndef SYNTHESIS
  // The credit rule must make a push into a full FIFO impossible.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (32'(fifo_cnt_q) == DEPTH)));

  a_out_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (32'(out_cnt_q) <= MAX_OUT));

  a_discard_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (discard_q <= out_cnt_q));

  a_fifo_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (32'(fifo_cnt_q) <= DEPTH));
`endif

endmodule

// File: tb/tb_rv32_prefetch_buffer.sv
// ---------------------------------------------------------------------------------------------
// tb_rv32_prefetch_buffer
//
// Randomized bench for rv32_prefetch_buffer. A behavioural instruction memory answers grants
// in order after a random delay; a reference model tracks the expected fetch PC, the queue of
// in-flight fetch addresses (marking them stale on redirect) and the queue of PCs waiting for
// decode. Every cycle the DUT's request, address, valid and presented {pc, instr} are compared
// against the model.
// ---------------------------------------------------------------------------------------------
module tb_rv32_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  rv32_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pops   = 0;
  int unsigned n_redir  = 0;
  int unsigned cyc      = 0;

  // Reference model state.
  logic [31:0] exp_fetch_pc;
  logic [31:0] pend_addr  [$];  // granted fetch addresses, oldest first
  bit          pend_stale [$];  // response will be dropped
  int unsigned pend_cyc   [$];  // cycle of grant
  logic [31:0] mfifo_pc   [$];  // PCs buffered for decode

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    exp_fetch_pc = RESET_PC;
    pend_addr.delete();
    pend_stale.delete();
    pend_cyc.delete();
    mfifo_pc.delete();
  endtask

  task automatic do_reset(input int unsigned cycles);
    @(negedge clk_i);
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    #1;
    check_eq("rst_req", imem_req_o, 1'b0);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
    model_reset();
    repeat (cycles) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model.
  task automatic step(input int unsigned gnt_pct, input int unsigned rv_pct,
                      input int unsigned rdy_pct, input int unsigned redir_pct);
    bit          can_rv, byp, exp_req, exp_valid, grant, pop_ev, s;
    int unsigned live;
    logic [31:0] exp_pc, a, rpc;

    @(negedge clk_i);
    can_rv        = (pend_addr.size() > 0) && (pend_cyc[0] < cyc);
    imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid_i = can_rv && ($urandom_range(0, 99) < rv_pct);
    imem_rdata_i  = can_rv ? mem_word(pend_addr[0]) : $urandom;
    instr_ready_i = ($urandom_range(0, 99) < rdy_pct);
    redirect_i    = ($urandom_range(0, 99) < redir_pct);
    rpc           = $urandom;
    if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
    redirect_pc_i = rpc;
    #1;

    live = 0;
    foreach (pend_stale[i]) if (!pend_stale[i]) live++;
    exp_req = !redirect_i && (pend_addr.size() < MAX_OUT) && (mfifo_pc.size() + live < DEPTH);

    byp = 1'b0;
`ifdef PFB_BYPASS_EN
    byp = !redirect_i && (mfifo_pc.size() == 0) && instr_ready_i && imem_rvalid_i &&
          !pend_stale[0];
`endif
    exp_valid = !redirect_i && ((mfifo_pc.size() != 0) || byp);

    check_eq("imem_req", imem_req_o, exp_req);
    check_eq("imem_addr", imem_addr_o, exp_fetch_pc);
    check_eq("instr_valid", instr_valid_o, exp_valid);
    if (exp_valid) begin
      exp_pc = byp ? pend_addr[0] : mfifo_pc[0];
      check_eq("instr_pc", instr_pc_o, exp_pc);
      check_eq("instr", instr_o, mem_word(exp_pc));
    end

    grant  = exp_req && imem_gnt_i;
    pop_ev = exp_valid && instr_ready_i;
    s      = 1'b1;
    a      = '0;
    if (imem_rvalid_i) begin
      a = pend_addr.pop_front();
      s = pend_stale.pop_front();
      void'(pend_cyc.pop_front());
    end
    if (redirect_i) begin
      n_redir++;
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      mfifo_pc.delete();
      exp_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop_ev) begin
        n_pops++;
        if (!byp) void'(mfifo_pc.pop_front());
      end
      if (imem_rvalid_i && !s && !byp) mfifo_pc.push_back(a);
      if (grant) begin
        pend_addr.push_back(exp_fetch_pc);
        pend_stale.push_back(1'b0);
        pend_cyc.push_back(cyc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    model_reset();
    do_reset(3);

    // Streaming with immediate grant/response and decode always ready.
    repeat (200) step(100, 100, 100, 0);
    // Decode stalls: FIFO fills, requests stop; then drains in order.
    repeat (25) step(100, 100, 0, 0);
    repeat (50) step(100, 100, 100, 0);
    // Random traffic with redirects (including near-wrap targets).
    repeat (2500) step(70, 60, 70, 5);
    // Reset in the middle of traffic, then more random traffic.
    do_reset(2);
    repeat (600) step(60, 50, 60, 8);

    check_eq("progress_pops", (n_pops > 500), 1'b1);
    check_eq("progress_redirects", (n_redir > 10), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
